// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: buffered entry layout and FSM states.
package fetch_pkg;
  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of {pc, instr} entries between fetch and decode; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  fetch_entry_t   r_mem [DEPTH];

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and buffers {pc, instr} for decode.
//   state  | meaning
//   S_IDLE | one dead cycle after reset, no fetch
//   S_RUN  | fetching whenever the buffer has room (or is draining this cycle)
//   S_HALT | no fetch; left only by a redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               IMEM_DEPTH = 1024,
  parameter int               XLEN       = FETCH_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_read_enable,
  output logic [$clog2(IMEM_DEPTH)-1:0]  imem_read_addr,
  input  logic [XLEN-1:0]                imem_read_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_pc,
  output logic [XLEN-1:0]                out_instr,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  input  logic                           halt_req,
  output logic                           halted
);
  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0]          r_pc;
  fetch_state_e             r_state;
  logic                     r_halted;

  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  fetch_entry_t             w_head;
  logic                     w_pop;
  logic                     w_fetch;

  assign w_pop   = !w_empty && out_ready;
  assign w_fetch = (r_state == S_RUN) && !redirect_valid && (!w_full || w_pop);

  assign imem_read_enable = w_fetch;
  // The address is held at zero in the post-reset dead cycle so reset state reads clean.
  assign imem_read_addr   = (r_state == S_IDLE) ? '0 : r_pc[ADDR_W+1:2];

  assign out_valid = (w_count != '0);
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign halted    = r_halted;

  // A redirect flushes the buffer, which also overrides any same-cycle pop.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fetch),
    .i_pop   (w_pop && !redirect_valid),
    .i_flush (redirect_valid),
    .i_data  ('{pc: r_pc, instr: imem_read_data}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: begin
          if (w_fetch) r_pc <= r_pc + XLEN'(INSTR_BYTES);
          if (halt_req) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en, valid, ready, rv, hr, halted;
  logic [9:0]  addr;
  logic [31:0] rdata, opc, oinstr, rpc;

  logic        w_en, w_valid, w_halted;
  logic [9:0]  w_addr;
  logic [31:0] w_rdata, w_opc, w_oinstr;

  assign rdata   = 32'hA000_0000 + 32'(addr);
  assign w_rdata = 32'hA000_0000 + 32'(w_addr);

  fetch_unit #(.IMEM_DEPTH(1024), .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_read_enable(en), .imem_read_addr(addr),
    .imem_read_data(rdata), .out_valid(valid), .out_ready(ready), .out_pc(opc),
    .out_instr(oinstr), .redirect_valid(rv), .redirect_pc(rpc), .halt_req(hr),
    .halted(halted)
  );

  fetch_unit #(.IMEM_DEPTH(1024), .XLEN(32), .RESET_PC(32'hFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .imem_read_enable(w_en), .imem_read_addr(w_addr),
    .imem_read_data(w_rdata), .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_opc),
    .out_instr(w_oinstr), .redirect_valid(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
    .halted(w_halted)
  );

  int n_pass = 0, n_total = 0, n_fail = 0, n_fetch = 0;

  // Model: buffered {pc, instr} pairs, next PC, and mode 0=after reset, 1=fetching, 2=halted.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  int          mode;

  function automatic logic [31:0] mem_of(input logic [31:0] p);
    return 32'hA000_0000 + {22'b0, p[11:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    mode = 0;
  endtask

  task automatic step(input bit rdy, input bit r_v, input logic [31:0] r_pc, input bit h);
    bit e_pop, e_fetch;
    ready = rdy; rv = r_v; rpc = r_pc; hr = h;
    #1;
    e_pop   = (q.size() > 0) && rdy;
    e_fetch = (mode == 1) && !r_v && ((q.size() < 2) || e_pop);
    chk("enable", 32'(en), 32'(e_fetch));
    chk("valid", 32'(valid), 32'(q.size() > 0));
    chk("halted", 32'(halted), 32'(mode == 2));
    if (e_fetch) chk("addr", 32'(addr), 32'(m_pc[11:2]));
    if (q.size() > 0) begin
      chk("out_pc", opc, q[0][63:32]);
      chk("out_instr", oinstr, q[0][31:0]);
    end
    if (e_fetch) n_fetch++;
    if (r_v) begin
      q.delete();
      m_pc = r_pc & ~32'h3;
      mode = 1;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_fetch) begin
        q.push_back({m_pc, mem_of(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (mode == 0) mode = 1;
      else if (mode == 1 && h) mode = 2;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; rv = 1'b0; rpc = '0; hr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_enable", 32'(en), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_out_pc", opc, 32'h0);
    chk("rst_out_instr", oinstr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure from release; the wrap instance streams freely alongside.
    n_fetch = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        chk("wrap_en1", 32'(w_en), 32'h1);
        chk("wrap_addr1", 32'(w_addr), 32'h3FF);
      end
      if (i == 2) begin
        chk("wrap_addr2", 32'(w_addr), 32'h000);
        chk("wrap_pc2", w_opc, 32'hFFC);
      end
      if (i == 3) begin
        chk("wrap_pc3", w_opc, 32'h1000);
        chk("wrap_instr3", w_oinstr, 32'hA000_0000);
      end
      if (i == 5) chk("bp_fetches", 32'(n_fetch), 32'd2);
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("bp_hold_pc", opc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect with entries buffered
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h203, 1'b0);
    rv = 1'b0; ready = 1'b1;
    #1;
    chk("redir_valid", 32'(valid), 32'h0);
    chk("redir_addr", 32'(addr), 32'h80);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Halt, drain, resume via redirect
    step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_level", 32'(halted), 32'h1);
    step(1'b1, 1'b1, 32'h40, 1'b0);
    rv = 1'b0;
    #1;
    chk("resume_addr", 32'(addr), 32'h10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Async reset with the buffer full
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_enable", 32'(en), 32'h0);
    chk("arst_out_pc", opc, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 500; i++)
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 19) == 0),
           $urandom(), bit'($urandom_range(0, 29) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
